// File: rtl/cpu_fsm_controller_if.sv
// cpu_fsm_controller_if: decoder fields and start request in, datapath controls and idle flag out
interface cpu_fsm_controller_if;
  logic       s;
  logic [2:0] opcode;
  logic [1:0] op;
  logic       w;
  logic [2:0] nsel;
  logic [3:0] vsel;
  logic       loada;
  logic       loadb;
  logic       asel;
  logic       bsel;
  logic       loadc;
  logic       loads;
  logic       write;
  logic       err;
  modport master(
    output s, opcode, op,
    input  w, nsel, vsel, loada, loadb, asel, bsel, loadc, loads, write, err
  );
  modport slave(
    input  s, opcode, op,
    output w, nsel, vsel, loada, loadb, asel, bsel, loadc, loads, write, err
  );
endinterface

// File: rtl/cpu_fsm_controller.sv
// cpu_fsm_controller: Moore sequencer for the single-issue register/ALU datapath
module cpu_fsm_controller #(
  parameter int STATE_W = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  cpu_fsm_controller_if.slave  bus
);
  localparam logic [STATE_W-1:0] S_WAIT      = STATE_W'(0);
  localparam logic [STATE_W-1:0] S_DECODE    = STATE_W'(1);
  localparam logic [STATE_W-1:0] S_WRITE_IMM = STATE_W'(2);
  localparam logic [STATE_W-1:0] S_GET_A     = STATE_W'(3);
  localparam logic [STATE_W-1:0] S_GET_B     = STATE_W'(4);
  localparam logic [STATE_W-1:0] S_EXEC      = STATE_W'(5);
  localparam logic [STATE_W-1:0] S_EXEC_B    = STATE_W'(6);
  localparam logic [STATE_W-1:0] S_CMP_EXEC  = STATE_W'(7);
  localparam logic [STATE_W-1:0] S_WRITE_REG = STATE_W'(8);
  localparam logic [STATE_W-1:0] S_ILLEGAL   = STATE_W'(9);
  logic [STATE_W-1:0] state, state_nx;
  logic is_movi, is_movr, is_alu, is_cmp, is_mvn;
  assign is_movi = bus.opcode == 3'b110 && bus.op == 2'b10;
  assign is_movr = bus.opcode == 3'b110 && bus.op == 2'b00;
  assign is_alu  = bus.opcode == 3'b101 && !bus.op[0];
  assign is_cmp  = bus.opcode == 3'b101 && bus.op == 2'b01;
  assign is_mvn  = bus.opcode == 3'b101 && bus.op == 2'b11;
  // State register; reset aborts any instruction before its write cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_WAIT;
    else          state <= state_nx;
  end
  // Next state; terminal and unreachable states fall back to WAIT
  always_comb begin
    state_nx = S_WAIT;
    case (state)
      S_WAIT:   state_nx = bus.s ? S_DECODE : S_WAIT;
      S_DECODE: state_nx = is_movi ? S_WRITE_IMM :
                           (is_movr || is_mvn) ? S_GET_B :
                           (is_alu || is_cmp) ? S_GET_A : S_ILLEGAL;
      S_GET_A:  state_nx = S_GET_B;
      S_GET_B:  state_nx = is_alu ? S_EXEC : is_cmp ? S_CMP_EXEC : S_EXEC_B;
      S_EXEC:   state_nx = S_WRITE_REG;
      S_EXEC_B: state_nx = S_WRITE_REG;
      default:  state_nx = S_WAIT;
    endcase
  end
  // Moore outputs decoded from the state alone
  always_comb begin
    bus.w     = state == S_WAIT;
    bus.nsel  = {state == S_WRITE_IMM || state == S_GET_A, state == S_WRITE_REG, state == S_GET_B};
    bus.vsel  = {2'b00, state == S_WRITE_IMM, state == S_WRITE_REG};
    bus.loada = state == S_GET_A;
    bus.loadb = state == S_GET_B;
    bus.asel  = state == S_EXEC_B;
    bus.bsel  = 1'b0;
    bus.loadc = state == S_EXEC || state == S_EXEC_B;
    bus.loads = state == S_CMP_EXEC;
    bus.write = state == S_WRITE_IMM || state == S_WRITE_REG;
    bus.err   = state == S_ILLEGAL;
  end
endmodule

// File: tb/tb_cpu_fsm_controller.sv
// tb_cpu_fsm_controller: instruction-level model plus directed sequences for the CPU controller
module tb_cpu_fsm_controller;
  logic clk = 1'b0;
  logic reset_n;
  int tests = 0;
  int fails = 0;
  cpu_fsm_controller_if bus();
  cpu_fsm_controller #(.STATE_W(4)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  // output word: {w, nsel, vsel, loada, loadb, asel, bsel, loadc, loads, write, err}
  localparam logic [15:0] IDLE  = 16'b1_000_0000_00000000;
  localparam logic [15:0] DEC   = 16'b0_000_0000_00000000;
  localparam logic [15:0] WIMM  = 16'b0_100_0010_00000010;
  localparam logic [15:0] GETA  = 16'b0_100_0000_10000000;
  localparam logic [15:0] GETB  = 16'b0_001_0000_01000000;
  localparam logic [15:0] EXEC  = 16'b0_000_0000_00001000;
  localparam logic [15:0] EXECB = 16'b0_000_0000_00101000;
  localparam logic [15:0] CMPX  = 16'b0_000_0000_00000100;
  localparam logic [15:0] WREG  = 16'b0_010_0001_00000010;
  localparam logic [15:0] ILL   = 16'b0_000_0000_00000001;
  logic [15:0] dw;
  assign dw = {bus.w, bus.nsel, bus.vsel, bus.loada, bus.loadb, bus.asel, bus.bsel,
               bus.loadc, bus.loads, bus.write, bus.err};
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // Model: an accepted start enqueues the whole per-cycle output sequence of that instruction
  logic [15:0] q[$];
  function automatic void push_seq(input logic [2:0] oc, input logic [1:0] ov);
    if (oc == 3'b110 && ov == 2'b10) q = '{DEC, WIMM};
    else if (oc == 3'b110 && ov == 2'b00) q = '{DEC, GETB, EXECB, WREG};
    else if (oc == 3'b101 && (ov == 2'b00 || ov == 2'b10)) q = '{DEC, GETA, GETB, EXEC, WREG};
    else if (oc == 3'b101 && ov == 2'b01) q = '{DEC, GETA, GETB, CMPX};
    else if (oc == 3'b101 && ov == 2'b11) q = '{DEC, GETB, EXECB, WREG};
    else q = '{DEC, ILL};
  endfunction
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) q.delete();
    else if (q.size() == 0) begin
      if (bus.s) push_seq(bus.opcode, bus.op);
    end else void'(q.pop_front());
  end
  always @(negedge clk) chk("cycle", 32'(dw), 32'(q.size() == 0 ? IDLE : q[0]));
  task automatic run(input string nm, input logic [2:0] oc, input logic [1:0] ov,
                     input int eb, input int ewr, input int eld, input int eer, input int ela);
    int busy = 0, wr = 0, ld = 0, er = 0, la = 0;
    @(negedge clk);
    bus.opcode = oc;
    bus.op = ov;
    bus.s = 1'b1;
    @(negedge clk);
    bus.s = 1'b0;
    while (!bus.w && busy < 20) begin
      busy++;
      wr += int'(bus.write);
      ld += int'(bus.loads);
      er += int'(bus.err);
      la += int'(bus.loada);
      @(negedge clk);
    end
    chk({nm, "_busy"}, busy, eb);
    chk({nm, "_write"}, wr, ewr);
    chk({nm, "_loads"}, ld, eld);
    chk({nm, "_err"}, er, eer);
    chk({nm, "_loada"}, la, ela);
  endtask
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
  initial begin
    logic [5:0] wpat;
    int n;
    bus.s = 1'b0;
    bus.opcode = 3'b000;
    bus.op = 2'b00;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    @(negedge clk);
    chk("reset_state", 32'(dw), 32'(IDLE));
    run("movi", 3'b110, 2'b10, 2, 1, 0, 0, 0);
    run("movr", 3'b110, 2'b00, 4, 1, 0, 0, 0);
    run("add",  3'b101, 2'b00, 5, 1, 0, 0, 1);
    run("and",  3'b101, 2'b10, 5, 1, 0, 0, 1);
    run("cmp",  3'b101, 2'b01, 4, 0, 1, 0, 1);
    run("mvn",  3'b101, 2'b11, 4, 1, 0, 0, 0);
    run("ill011", 3'b011, 2'b00, 2, 0, 0, 1, 0);
    run("ill110_01", 3'b110, 2'b01, 2, 0, 0, 1, 0);
    // async reset while an ADD sits in its B-operand load cycle
    bus.opcode = 3'b101;
    bus.op = 2'b00;
    bus.s = 1'b1;
    n = 0;
    @(negedge clk);
    bus.s = 1'b0;
    while (!bus.loadb && n < 10) begin
      n++;
      @(negedge clk);
    end
    chk("rst_reach_getb", 32'(bus.loadb), 32'd1);
    #1 reset_n = 1'b0;
    #1 chk("rst_async", 32'(dw), 32'(IDLE));
    @(posedge clk);
    #3 reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_hold_wait", 32'(bus.w), 32'd1);
    end
    // s held high over back-to-back MOV imm
    bus.opcode = 3'b110;
    bus.op = 2'b10;
    wpat[5] = bus.w;
    bus.s = 1'b1;
    for (int i = 4; i >= 0; i--) begin
      @(negedge clk);
      wpat[i] = bus.w;
    end
    bus.s = 1'b0;
    chk("b2b_wpattern", 32'(wpat), 32'b100100);
    @(negedge clk);
    chk("b2b_idle", 32'(bus.w), 32'd1);
    // s toggling while busy must not launch another instruction
    bus.opcode = 3'b101;
    bus.op = 2'b00;
    bus.s = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.s = (i % 2 == 1);
    end
    bus.s = 1'b0;
    @(negedge clk);
    chk("toggle_done", 32'(bus.w), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("toggle_no_restart", 32'(bus.w), 32'd1);
    end
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
